// File: rtl/sva_rep_pkg.sv
// Shared types and sizing helpers for the SVA repetition monitor.
// The optional watchdog is enabled by defining SVA_REP_MON_TIMEOUT_EN.
package sva_rep_pkg;

  typedef enum logic {
    GOTO      = 1'b0,
    NONCONSEC = 1'b1
  } rep_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rep_state_e;

  // Counter must hold MAX+1 so an excess event is representable without wrap.
  function automatic int CNT_W(input int max);
    return $clog2(max + 2);
  endfunction

endpackage

// File: rtl/sva_rep_chan.sv
// Single-channel lowering of start ##1 ev[->MIN:MAX] / ev[=MIN:MAX] ##1 done.
// Watchdog age counter is built only when SVA_REP_MON_TIMEOUT_EN is defined.
module sva_rep_chan
  import sva_rep_pkg::*;
#(
  parameter int MIN     = 2,
  parameter int MAX     = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic ev_i,
  input  logic done_i,
  output logic busy_o,
  output logic pass_o,
  output logic fail_o,
  output logic overlap_err_o,
  output logic timeout_o
);

  localparam int                CW     = CNT_W(MAX);
  localparam logic [CW-1:0]     MIN_C  = CW'(MIN);
  localparam logic [CW-1:0]     MAX_C  = CW'(MAX);
  localparam logic [CW-1:0]     SAT_C  = CW'(MAX + 1);
  localparam rep_mode_e         MODE_E = (MODE == 0) ? GOTO : NONCONSEC;

  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("sva_rep_chan: TIMEOUT must be >= 2");
  end

  rep_state_e    state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pass_q, fail_q, ovl_q, to_q;
  logic          dec_pass, dec_fail, dec_to;

  function automatic logic in_range(input logic [CW-1:0] v);
    return (v >= MIN_C) && (v <= MAX_C);
  endfunction

  always_comb begin
    cnt_d    = (cnt_q == SAT_C) ? cnt_q : cnt_q + CW'(1);
    pend_d   = (MODE_E == GOTO) && in_range(cnt_d);
    dec_pass = 1'b0;
    dec_fail = 1'b0;
    if (state_q == ACTIVE) begin
      if (MODE_E == GOTO) begin
        // pend marks "the in-range event happened last cycle", so done must follow it immediately
        if (pend_q && done_i)               dec_pass = 1'b1;
        else if (pend_q && cnt_q == MAX_C)  dec_fail = 1'b1;
      end else begin
        if (done_i && in_range(cnt_q))      dec_pass = 1'b1;
        else if (ev_i && cnt_q == MAX_C)    dec_fail = 1'b1;
      end
    end
  end

`ifdef SVA_REP_MON_TIMEOUT_EN
  localparam int            AW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] TO_C = AW'(TIMEOUT);
  logic [AW-1:0] age_q;

  assign dec_to = (state_q == ACTIVE) && !dec_pass && !dec_fail && (age_q == TO_C);

  // Age is preloaded to 1 while idle so it equals (cycle - t0) once active.
  always_ff @(posedge clk) begin
    if (rst)                    age_q <= AW'(1);
    else if (state_q == IDLE)   age_q <= AW'(1);
    else if (age_q != TO_C)     age_q <= age_q + AW'(1);
  end
`else
  assign dec_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ovl_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      pass_q <= dec_pass;
      fail_q <= dec_fail | dec_to;
      to_q   <= dec_to;
      ovl_q  <= (state_q == ACTIVE) && start_i;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (dec_pass || dec_fail || dec_to) begin
            state_q <= IDLE;
          end else if (ev_i) begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
          end else begin
            pend_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o        = (state_q == ACTIVE);
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign overlap_err_o = ovl_q;
  assign timeout_o     = to_q;

endmodule

// File: rtl/sva_rep_monitor.sv
// NCH independent repetition checkers (goto or non-consecutive, set by MODE).
// Define SVA_REP_MON_TIMEOUT_EN to add a per-channel TIMEOUT-cycle watchdog.
module sva_rep_monitor
  import sva_rep_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN     = 2,
  parameter int MAX     = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] ev,
  input  logic [NCH-1:0] done,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] pass,
  output logic [NCH-1:0] fail,
  output logic [NCH-1:0] overlap_err,
  output logic [NCH-1:0] timeout
);

  if (NCH < 1 || NCH > 32) begin : g_chk_nch
    $error("sva_rep_monitor: NCH must be in 1..32");
  end
  if (MIN < 1 || MIN > MAX) begin : g_chk_min
    $error("sva_rep_monitor: MIN must satisfy 1 <= MIN <= MAX");
  end
  if (MAX > 255) begin : g_chk_max
    $error("sva_rep_monitor: MAX must be <= 255");
  end
  if (MODE != 0 && MODE != 1) begin : g_chk_mode
    $error("sva_rep_monitor: MODE must be 0 (goto) or 1 (non-consecutive)");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sva_rep_chan #(
      .MIN     (MIN),
      .MAX     (MAX),
      .MODE    (MODE),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start[i]),
      .ev_i          (ev[i]),
      .done_i        (done[i]),
      .busy_o        (busy[i]),
      .pass_o        (pass[i]),
      .fail_o        (fail[i]),
      .overlap_err_o (overlap_err[i]),
      .timeout_o     (timeout[i])
    );
  end

endmodule

// File: tb/tb_sva_rep_monitor.sv
// Bench for sva_rep_monitor: a goto and a non-consecutive instance share stimulus,
// an event-history model predicts every output, and directed scenarios pin literals.
`timescale 1ns/1ps
module tb_sva_rep_monitor;

  localparam int NCH = 4;
  localparam int MIN = 2;
  localparam int MAX = 4;
  localparam int TO  = 8;
  localparam int L   = 22;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] start = '0, ev = '0, done = '0;
  logic [NCH-1:0] busy [2];
  logic [NCH-1:0] pass [2];
  logic [NCH-1:0] fail [2];
  logic [NCH-1:0] ovl  [2];
  logic [NCH-1:0] tmo  [2];

  sva_rep_monitor #(.NCH(NCH), .MIN(MIN), .MAX(MAX), .MODE(0), .TIMEOUT(TO)) u_goto (
    .clk(clk), .rst(rst), .start(start), .ev(ev), .done(done),
    .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .overlap_err(ovl[0]), .timeout(tmo[0]));

  sva_rep_monitor #(.NCH(NCH), .MIN(MIN), .MAX(MAX), .MODE(1), .TIMEOUT(TO)) u_nc (
    .clk(clk), .rst(rst), .start(start), .ev(ev), .done(done),
    .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .overlap_err(ovl[1]), .timeout(tmo[1]));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [NCH-1:0] e_busy [2];
  logic [NCH-1:0] e_pass [2];
  logic [NCH-1:0] e_fail [2];
  logic [NCH-1:0] e_ovl  [2];
  logic [NCH-1:0] e_tmo  [2];

  // Model state: attempt open?, start edge, events seen since start, edge of last counted event.
  bit m_act  [2][NCH];
  int m_t0   [2][NCH];
  int m_n    [2][NCH];
  int m_last [2][NCH];

  task automatic check(input string nm, input int d, input int c, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s dut%0d ch%0d cyc%0d: got %b expected %b", nm, d, c, cyc, act, exp);
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        bit ps, fl, to, prev, inr;
        ps = 1'b0; fl = 1'b0; to = 1'b0;
        e_ovl[d][c] = 1'b0;
        if (rst) begin
          m_act[d][c] = 1'b0;
        end else begin
          e_ovl[d][c] = m_act[d][c] && start[c];
          if (!m_act[d][c]) begin
            if (start[c]) begin
              m_act[d][c]  = 1'b1;
              m_t0[d][c]   = cyc;
              m_n[d][c]    = 0;
              m_last[d][c] = -10;
            end
          end else begin
            prev = (m_last[d][c] == cyc - 1);
            inr  = (m_n[d][c] >= MIN) && (m_n[d][c] <= MAX);
            if (d == 0) begin
              if (prev && inr && done[c])            ps = 1'b1;
              else if (prev && m_n[d][c] == MAX)     fl = 1'b1;
            end else begin
              if (cyc >= m_t0[d][c] + 2 && inr && done[c]) ps = 1'b1;
              else if (ev[c] && m_n[d][c] == MAX)          fl = 1'b1;
            end
`ifdef SVA_REP_MON_TIMEOUT_EN
            if (!ps && !fl && (cyc - m_t0[d][c]) == TO) begin
              fl = 1'b1;
              to = 1'b1;
            end
`endif
            if (ps || fl) m_act[d][c] = 1'b0;
            else if (ev[c]) begin
              m_n[d][c]    = m_n[d][c] + 1;
              m_last[d][c] = cyc;
            end
          end
        end
        e_pass[d][c] = ps;
        e_fail[d][c] = fl;
        e_tmo[d][c]  = to;
        e_busy[d][c] = m_act[d][c];
      end
    end
    cyc++;
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          check("model_busy", d, c, busy[d][c], e_busy[d][c]);
          check("model_pass", d, c, pass[d][c], e_pass[d][c]);
          check("model_fail", d, c, fail[d][c], e_fail[d][c]);
          check("model_ovl",  d, c, ovl[d][c],  e_ovl[d][c]);
          check("model_tmo",  d, c, tmo[d][c],  e_tmo[d][c]);
        end
      end
    end
  end

  task automatic rand_in(input int from);
    for (int c = from; c < NCH; c++) begin
      start[c] = ($urandom_range(0, 5) == 0);
      ev[c]    = ($urandom_range(0, 1) == 0);
      done[c]  = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Channel 0 follows the bit masks (bit k = cycle k); other channels run random traffic.
  task automatic scn(input string nm, input int d, input logic [31:0] st, input logic [31:0] evm,
                     input logic [31:0] dnm, input logic [31:0] rsm, input logic [31:0] ep,
                     input logic [31:0] ef, input logic [31:0] eb, input logic [31:0] eo,
                     input logic [31:0] et);
    @(negedge clk);
    rst = 1'b1;
    rand_in(1);
    start[0] = 1'b0; ev[0] = 1'b0; done[0] = 1'b0;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      check({nm, "_pass"}, d, 0, pass[d][0], ep[k]);
      check({nm, "_fail"}, d, 0, fail[d][0], ef[k]);
      check({nm, "_busy"}, d, 0, busy[d][0], eb[k]);
      check({nm, "_ovl"},  d, 0, ovl[d][0],  eo[k]);
      check({nm, "_tmo"},  d, 0, tmo[d][0],  et[k]);
      rst = rsm[k];
      rand_in(1);
      start[0] = st[k];
      ev[0]    = evm[k];
      done[0]  = dnm[k];
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    //    name         d  start  ev     done   rst    pass   fail   busy      ovl    tmo
    scn("goto_basic",  0, 32'h1, 32'h24, 32'h40, 32'h0, 32'h80, 32'h0, 32'h7E, 32'h0, 32'h0);
    scn("goto_minlat", 0, 32'h1, 32'h06, 32'h08, 32'h0, 32'h10, 32'h0, 32'h0E, 32'h0, 32'h0);
    scn("goto_max",    0, 32'h1, 32'h1E, 32'h00, 32'h0, 32'h0,  32'h40, 32'h3E, 32'h0, 32'h0);
    scn("nc_excess",   1, 32'h1, 32'h3E, 32'h00, 32'h0, 32'h0,  32'h40, 32'h3E, 32'h0, 32'h0);
    scn("nc_prio",     1, 32'h1, 32'h3E, 32'h20, 32'h0, 32'h40, 32'h0,  32'h3E, 32'h0, 32'h0);
    scn("overlap",     0, 32'h9, 32'h24, 32'h40, 32'h0, 32'h80, 32'h0,  32'h7E, 32'h10, 32'h0);
    scn("reset_mid",   0, 32'h1, 32'h24, 32'h40, 32'h8, 32'h0,  32'h0,  32'h0E, 32'h0, 32'h0);
`ifdef SVA_REP_MON_TIMEOUT_EN
    scn("nc_late",     1, 32'h1, 32'h14, 32'h200, 32'h0, 32'h0, 32'h200, 32'h1FE, 32'h0, 32'h200);
    scn("nc_early",    1, 32'h1, 32'h14, 32'h08,  32'h0, 32'h0, 32'h200, 32'h1FE, 32'h0, 32'h200);
    scn("nc_watchdog", 1, 32'h1, 32'h06, 32'h00,  32'h0, 32'h0, 32'h200, 32'h1FE, 32'h0, 32'h200);
`else
    scn("nc_late",     1, 32'h1, 32'h14, 32'h200, 32'h0, 32'h400, 32'h0, 32'h3FE, 32'h0, 32'h0);
    scn("nc_early",    1, 32'h1, 32'h14, 32'h08,  32'h0, 32'h0,   32'h0, 32'h3FFFFE, 32'h0, 32'h0);
    scn("nc_watchdog", 1, 32'h1, 32'h06, 32'h00,  32'h0, 32'h0,   32'h0, 32'h3FFFFE, 32'h0, 32'h0);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      rand_in(0);
    end
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/sva_rep_monitor.md
# sva_rep_monitor

Synthesizable multi-channel checker for the SVA sequence forms `start ##1 ev[->MIN:MAX] ##1 done` (goto) and `start ##1 ev[=MIN:MAX] ##1 done` (non-consecutive). It lowers both repetition operators to per-channel counters and small FSMs. It sits beside the SVA frontend as the reference lowering target and as a standalone bus-protocol monitor, and reports per-channel pass/fail pulses.

## Interface
- `NCH`, 4: number of independent channels, 1..32.
- `MIN`, 2: minimum repetition count, 1 ≤ MIN ≤ MAX.
- `MAX`, 4: maximum repetition count, ≤ 255.
- `MODE`, 0: 0 = goto `[->]`, 1 = non-consecutive `[=]`; common to all channels.
- `TIMEOUT`, 64: attempt watchdog in cycles, ≥ 2. Used only with the macro.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in NCH: per-channel attempt trigger.
- `ev` in NCH: per-channel repeated event.
- `done` in NCH: per-channel terminating condition.
- `busy` out NCH: attempt in progress.
- `pass` out NCH: one-cycle pulse, attempt matched.
- `fail` out NCH: one-cycle pulse, attempt failed.
- `overlap_err` out NCH: one-cycle pulse, start ignored while busy.
- `timeout` out NCH: one-cycle pulse accompanying a watchdog fail.

## Operation
- All outputs reset to 0; every channel returns to IDLE with cnt=0.
- Reset asserted mid-attempt aborts the attempt silently, with no pass or fail.
- Per-channel states: IDLE, ACTIVE.
- IDLE: `start`=1 at cycle t0 → ACTIVE, cnt=0, pend=0. The observation window starts at t0+1. `ev`/`done` at t0 are ignored.
- ACTIVE, `start`=1: ignored; `overlap_err` pulse. The attempt continues.
- cnt width is $clog2(MAX+2). cnt saturates at MAX+1 and never wraps.
- Goto mode, evaluated each ACTIVE cycle in this order:
  - If pend=1 and `done`=1 → pass.
  - Else if pend=1 and cnt==MAX → fail.
  - Otherwise, if `ev`=1 then cnt++. pend is set to 1 iff `ev`=1 and the new cnt is in [MIN,MAX].
  - `done` with pend=0 has no effect.
- Non-consecutive mode, evaluated each ACTIVE cycle in this order:
  - If cycle ≥ t0+2, `done`=1 and cnt (events in t0+1..t-1) is in [MIN,MAX] → pass.
  - Else if `ev`=1 and cnt==MAX → fail (excess events).
  - Otherwise, if `ev`=1 then cnt++.
  - `done` with cnt<MIN is ignored.
- Pass has priority over fail in the same cycle.
- On a decision the channel returns to IDLE in the next cycle. A `start` in that next cycle begins a new attempt.
- Channels are fully independent. There is no cross-channel arbitration.

## Timing
- Decision in cycle t → `pass`/`fail`/`timeout` high in cycle t+1, registered, for exactly one cycle.
- `busy` is high from t0+1 through the decision cycle t, and low at t+1.
- `overlap_err` is high in the cycle after the ignored `start`.
- Minimum attempt latency in goto mode: start at t0, MIN consecutive `ev` from t0+1, `done` at t0+MIN+1 → pass at t0+MIN+2.

## Configuration
- `SVA_REP_MON_TIMEOUT_EN` defined:
  - Each channel has an age counter, cleared at t0.
  - If no decision has occurred by cycle t0+TIMEOUT, that cycle is a fail decision, with `fail` and `timeout` both pulsed at t0+TIMEOUT+1.
  - A pass or fail decided in the same cycle takes priority, and `timeout` stays 0.
- Macro undefined:
  - No age counter is built and `timeout` is tied 0.
  - A non-consecutive attempt with cnt ≥ MIN and no `done` may stay ACTIVE indefinitely.

## Structure
- Package `sva_rep_pkg` holds:
  - the `rep_mode_e` enum (GOTO=0, NONCONSEC=1);
  - the `rep_state_e` enum (IDLE, ACTIVE);
  - the `CNT_W` function of MAX.
- Sub-module `sva_rep_chan` implements the single-channel FSM, counter and optional watchdog. The top generates NCH instances and elaborates parameter checks (MIN/MAX/NCH ranges) with `$error`.

## Test plan
All scenarios use MIN=2, MAX=4, channel 0 unless stated; start at cycle 0.
- Goto: `ev`@2,5, `done`@6 → `pass`@7; `busy` high 1..6.
- Goto: `ev`@1,2,3,4, `done` never → `fail`@6. The decision is at 5, with pend at cnt=MAX.
- Non-consecutive: `ev`@2,4, `done`@9 → `pass`@10. Same stimulus with `done`@3 only → no pass, still busy.
- Non-consecutive: `ev`@1..5 → `fail`@6. Variant: `ev`@1..5 plus `done`@5 → `pass`@6, pass priority over fail.
- Overlap and reset: extra `start`@3 → `overlap_err`@4, attempt unaffected. A separate run with `rst`@3 → all outputs 0 at 4, and no pass/fail ever. Channel 1 is driven concurrently and is unaffected.
- With `SVA_REP_MON_TIMEOUT_EN`, TIMEOUT=8, non-consecutive mode, `ev`@1,2, no `done` → `fail`+`timeout`@9. Without the macro the channel is still busy at 20.
